// File: rtl/fprti_issue_ctrl.sv
// Initiator for the FPRTI intersector: gathers 15 operand words, issues a one-cycle input_valid,
// then captures the result (or a timeout abort) and holds it until the host accepts it.
module fprti_issue_ctrl #(
    parameter int NUM_FPRTI_REGS = 15,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_valid_i,
    input  logic [3:0]                   wr_addr_i,
    input  logic [31:0]                  wr_data_i,
    output logic                         wr_ready_o,
    input  logic                         go_i,
    output logic                         busy_o,
    output logic                         err_incomplete_o,
    output logic [NUM_FPRTI_REGS*32-1:0] fprti_regs_o,
    output logic                         input_valid_o,
    input  logic                         output_valid_i,
    input  logic [31:0]                  return_i,
    output logic [31:0]                  result_o,
    output logic                         result_valid_o,
    input  logic                         result_ready_i,
    output logic                         err_timeout_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t                    state;
    logic [NUM_FPRTI_REGS-1:0] mask;
    logic [CW-1:0]             cnt;
    logic [31:0]               regs [NUM_FPRTI_REGS];
    logic                      addr_ok;

    assign addr_ok = ({28'd0, wr_addr_i} < 32'(NUM_FPRTI_REGS));

    for (genvar g = 0; g < NUM_FPRTI_REGS; g++) begin : g_regs_out
        assign fprti_regs_o[g*32 +: 32] = regs[g];
    end

    // Reset is active-high despite the name. wr_ready_o doubles as the "accepting" flag,
    // so the first cycle after reset neither takes writes nor judges go.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state            <= IDLE;
            mask             <= '0;
            cnt              <= '0;
            wr_ready_o       <= 1'b0;
            busy_o           <= 1'b0;
            err_incomplete_o <= 1'b0;
            input_valid_o    <= 1'b0;
            result_o         <= '0;
            result_valid_o   <= 1'b0;
            err_timeout_o    <= 1'b0;
            for (int i = 0; i < NUM_FPRTI_REGS; i++) regs[i] <= '0;
        end else begin
            input_valid_o    <= 1'b0;
            err_incomplete_o <= 1'b0;
            case (state)
                IDLE: begin
                    wr_ready_o <= 1'b1;
                    if (wr_ready_o && wr_valid_i && addr_ok) begin
                        regs[wr_addr_i] <= wr_data_i;
                        mask[wr_addr_i] <= 1'b1;
                    end
                    // go is judged on the mask as it stood before any same-cycle write
                    if (wr_ready_o && go_i) begin
                        if (&mask) begin
                            state         <= ISSUE;
                            mask          <= '0;
                            cnt           <= '0;
                            err_timeout_o <= 1'b0;
                            input_valid_o <= 1'b1;
                            busy_o        <= 1'b1;
                            wr_ready_o    <= 1'b0;
                        end else begin
                            err_incomplete_o <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt   <= cnt + 1'b1;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (output_valid_i) begin
                        result_o       <= return_i;
                        result_valid_o <= 1'b1;
                        state          <= HOLD;
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        result_o       <= '0;
                        err_timeout_o  <= 1'b1;
                        result_valid_o <= 1'b1;
                        state          <= HOLD;
                    end
                end
                HOLD: begin
                    if (result_ready_i) begin
                        result_valid_o <= 1'b0;
                        busy_o         <= 1'b0;
                        wr_ready_o     <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fprti_issue_ctrl.sv
// Bench for fprti_issue_ctrl: directed scenarios plus randomised ops, checked every cycle
// against a transaction-level model (phase + age since issue) and a few literal expectations.
module tb_fprti_issue_ctrl;
    localparam int N   = 15;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           wr_valid_i = 1'b0;
    logic [3:0]     wr_addr_i = '0;
    logic [31:0]    wr_data_i = '0;
    logic           wr_ready_o;
    logic           go_i = 1'b0;
    logic           busy_o;
    logic           err_incomplete_o;
    logic [N*32-1:0] fprti_regs_o;
    logic           input_valid_o;
    logic           output_valid_i = 1'b0;
    logic [31:0]    return_i = '0;
    logic [31:0]    result_o;
    logic           result_valid_o;
    logic           result_ready_i = 1'b0;
    logic           err_timeout_o;

    int checks = 0;
    int errors = 0;

    fprti_issue_ctrl #(.NUM_FPRTI_REGS(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .wr_ready_o(wr_ready_o), .go_i(go_i), .busy_o(busy_o),
        .err_incomplete_o(err_incomplete_o), .fprti_regs_o(fprti_regs_o),
        .input_valid_o(input_valid_o), .output_valid_i(output_valid_i),
        .return_i(return_i), .result_o(result_o), .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i), .err_timeout_o(err_timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [N*32-1:0] act, input logic [N*32-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 operation in flight, 2 result held. age counts cycles since input_valid.
    int          m_phase, m_age;
    bit          m_ready, m_busy, m_ivld, m_incomp, m_rvld, m_tmo;
    logic [31:0] m_res;
    logic [31:0] m_regs [N];
    bit [N-1:0]  m_loaded;

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            m_phase = 0; m_age = 0; m_ready = 0; m_busy = 0; m_ivld = 0; m_incomp = 0;
            m_rvld = 0; m_tmo = 0; m_res = '0; m_loaded = '0;
            for (int i = 0; i < N; i++) m_regs[i] = '0;
        end else begin
            bit all_loaded;
            m_ivld = 0; m_incomp = 0;
            if (m_phase == 0 && m_ready) begin
                all_loaded = (m_loaded == {N{1'b1}});
                if (wr_valid_i && int'(wr_addr_i) < N) begin
                    m_regs[wr_addr_i] = wr_data_i;
                    m_loaded[wr_addr_i] = 1'b1;
                end
                if (go_i) begin
                    if (all_loaded) begin
                        m_phase = 1; m_age = 0; m_ivld = 1; m_tmo = 0; m_loaded = '0;
                    end else m_incomp = 1;
                end
            end else if (m_phase == 1) begin
                if (m_age >= 1 && output_valid_i) begin
                    m_res = return_i; m_rvld = 1; m_phase = 2;
                end else if (m_age + 1 == TMO) begin
                    m_res = '0; m_tmo = 1; m_rvld = 1; m_phase = 2;
                end
                m_age++;
            end else if (m_phase == 2 && result_ready_i) begin
                m_rvld = 0; m_phase = 0;
            end
            m_ready = (m_phase == 0);
            m_busy  = (m_phase != 0);
        end
    end

    always @(negedge clk) begin
        logic [N*32-1:0] exp_regs;
        for (int i = 0; i < N; i++) exp_regs[i*32 +: 32] = m_regs[i];
        chk("wr_ready", wr_ready_o, m_ready);
        chk("busy", busy_o, m_busy);
        chk("input_valid", input_valid_o, m_ivld);
        chk("err_incomplete", err_incomplete_o, m_incomp);
        chk("result_valid", result_valid_o, m_rvld);
        chk("result", result_o, m_res);
        chk("err_timeout", err_timeout_o, m_tmo);
        chk("fprti_regs", fprti_regs_o, exp_regs);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wr_valid_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        tick();
        wr_valid_i = 1'b0;
    endtask

    task automatic load(input int last);
        for (int i = 0; i <= last; i++) wr(4'(i), 32'h1000_0000 + 32'(i) * 32'h0101);
    endtask

    task automatic go();
        go_i = 1'b1;
        tick();
        go_i = 1'b0;
    endtask

    task automatic wait_rv(output int n);
        n = 0;
        while (!result_valid_o && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            errors++;
            $display("FAIL wait_result_valid: timed out after %0d cycles, required result_valid_o=1", n);
        end
    endtask

    task automatic accept();
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
    endtask

    initial begin
        int n, lat;
        logic [31:0] ret;
        repeat (3) tick();
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_ready", wr_ready_o, 1'b0);
        rst_n = 1'b0;
        repeat (2) tick();
        chk("idle_ready", wr_ready_o, 1'b1);

        // 1: full load, issue, result after 5 cycles, delayed accept
        load(14);
        go();
        chk("t1_ivld_on", input_valid_o, 1'b1);
        tick();
        chk("t1_ivld_off", input_valid_o, 1'b0);
        repeat (4) tick();
        output_valid_i = 1'b1; return_i = 32'd1;
        tick();
        output_valid_i = 1'b0;
        chk("t1_result", result_o, 32'd1);
        chk("t1_rvld", result_valid_o, 1'b1);
        repeat (3) tick();
        chk("t1_hold", result_valid_o, 1'b1);
        accept();
        chk("t1_released", result_valid_o, 1'b0);
        chk("t1_idle", busy_o, 1'b0);

        // 2: incomplete mask rejects go
        load(13);
        go();
        chk("t2_incomp", err_incomplete_o, 1'b1);
        chk("t2_no_ivld", input_valid_o, 1'b0);
        tick();
        chk("t2_pulse_end", err_incomplete_o, 1'b0);
        chk("t2_not_busy", busy_o, 1'b0);

        // 5: same-cycle write of the last word and go: go rejected, next go accepted
        wr_valid_i = 1'b1; wr_addr_i = 4'd14; wr_data_i = 32'hCAFE_0014; go_i = 1'b1;
        tick();
        wr_valid_i = 1'b0; go_i = 1'b0;
        chk("t5_rejected", err_incomplete_o, 1'b1);
        go();
        chk("t5_accepted", input_valid_o, 1'b1);

        // 3: no response -> timeout 16 cycles after input_valid
        wait_rv(n);
        chk("t3_latency", 32'(n), 32'd16);
        chk("t3_tmo", err_timeout_o, 1'b1);
        chk("t3_result", result_o, 32'd0);
        accept();
        chk("t3_tmo_sticky", err_timeout_o, 1'b1);

        // 4: out-of-range write ignored; writes during WAIT ignored
        wr(4'd15, 32'hDEADBEEF);
        go();
        chk("t4_mask_empty", err_incomplete_o, 1'b1);
        load(14);
        go();
        chk("t4_tmo_cleared", err_timeout_o, 1'b0);
        tick();
        wr(4'd3, 32'hDEADBEEF);
        chk("t4_word3", fprti_regs_o[3*32 +: 32], 32'h1000_0303);
        output_valid_i = 1'b1; return_i = 32'h3F80_0000;
        tick();
        output_valid_i = 1'b0;
        chk("t4_result", result_o, 32'h3F80_0000);
        accept();

        // 6: reset mid-WAIT, later response dropped
        load(14);
        go();
        repeat (3) tick();
        #2 rst_n = 1'b1;
        #1;
        chk("t6_busy", busy_o, 1'b0);
        chk("t6_regs", fprti_regs_o, '0);
        tick();
        rst_n = 1'b0;
        output_valid_i = 1'b1; return_i = 32'd55;
        repeat (3) tick();
        output_valid_i = 1'b0;
        chk("t6_stray", result_valid_o, 1'b0);
        go();
        chk("t6_mask_cleared", err_incomplete_o, 1'b1);

        // randomised ops, mix of in-time responses and timeouts
        for (int op = 0; op < 20; op++) begin
            for (int i = 0; i < N; i++) wr(4'(i), $urandom);
            if ($urandom_range(0, 1) == 1) wr(4'd15, $urandom);
            go();
            lat = $urandom_range(1, 18);
            ret = $urandom;
            repeat (lat) tick();
            output_valid_i = 1'b1; return_i = ret;
            tick();
            output_valid_i = 1'b0;
            wait_rv(n);
            chk("rand_result", result_o, (lat <= TMO - 1) ? ret : 32'd0);
            chk("rand_tmo", err_timeout_o, (lat <= TMO - 1) ? 1'b0 : 1'b1);
            repeat ($urandom_range(0, 3)) tick();
            accept();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
